pinmux_msc_cfg_node: RTL and testbench
======================================

# pinmux_msc_cfg_node

Per-pin MSC configuration receiver for the pinmux pad ring. It deserializes configuration frames from the MSC serial config bus and holds them in shadow registers. On a commit strobe it copies them to the active `*_out_mscbus` control outputs that drive one pinmux pad cell. One instance sits beside each pad cell and is addressed by its cell index.

## Interface
Parameters:
- `CELL_INDEX`, 0: unicast address of this node (0..254); address 8'hFF is broadcast.
- `ADDR_WIDTH`, 8: frame address field width. Fixed at 8; no other value is supported.

Ports:
- `i_clk`  in  1  single clock; all logic on its rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_msc_frame`  in  1  high for the duration of one frame.
- `i_msc_valid`  in  1  qualifies `i_msc_sdi` for the current cycle.
- `i_msc_sdi`  in  1  serial data, MSB first.
- `i_msc_commit`  in  1  one-cycle pulse; copies shadow to active.
- `amsel_out_mscbus`, `ds0_out_mscbus`, `ds1_out_mscbus`, `slew_out_mscbus`, `schmitt_out_mscbus`, `mode0_out_mscbus`, `mode1_out_mscbus`, `inena_out_mscbus`, `dir_out_mscbus`, `pull_en_out_mscbus`, `pull_type_out_mscbus`  out  1 each  active pad controls.
- `pinmux_muxsel_out_mscbus`  out  5  active output function select.
- `in_function_en_out_mscbus`  out  32  active input function enables.
- `glitch_filter_debounce_clk_sel_out_mscbus`  out  2; `glitch_filter_bypass_out_mscbus`  out  3.
- `pes_en_out_mscbus`  out  8; `pes_in_en_out_mscbus`  out  1; `pes_safeval_out_mscbus`  out  2.
- `o_cfg_written`  out  1  one-cycle pulse when a shadow register is written.
- `o_frame_err`  out  1  one-cycle pulse on bad frame length.
- `o_parity_err`  out  1  sticky parity error flag.
- `o_busy`  out  1  high while in SHIFT or CHECK.

## Operation
- Frame fields, MSB first: addr[7:0], regsel[3:0], data[31:0], then parity (1 bit, when `PINMUX_MSC_PARITY_EN` is defined). FRAME_LEN is 45 with parity, 44 without.
- The shift register and a 6-bit bit counter advance only on cycles with `i_msc_frame && i_msc_valid`. The counter saturates at 63. Bits beyond FRAME_LEN are shifted in, but the count then no longer equals FRAME_LEN.
- FSM states:
  - IDLE → SHIFT when `i_msc_frame`=1. The first bit is captured in the same cycle if `i_msc_valid`=1.
  - SHIFT → CHECK when `i_msc_frame`=0.
  - CHECK → IDLE unconditionally.
- CHECK evaluates the captured frame and takes exactly one action:
  - count ≠ FRAME_LEN: pulse `o_frame_err`; no write.
  - parity fails (XOR of all 45 bits ≠ 0): set `o_parity_err`; no write.
  - addr ∉ {CELL_INDEX, 8'hFF}: no action.
  - regsel 0: shadow0 ← data[15:0] = {muxsel[4:0], pull_type, pull_en, dir, inena, mode1, mode0, schmitt, slew, ds1, ds0, amsel}. Bit 0 is amsel; bits 15:11 are muxsel.
  - regsel 1: shadow1 ← data[31:0] (in_function_en).
  - regsel 2: shadow2 ← data[15:0] = {pes_safeval[1:0], pes_in_en, pes_en[7:0], bypass[2:0], clk_sel[1:0]}. Bits 1:0 are clk_sel.
  - regsel 3..15: ignored; no pulse.
  - `o_cfg_written` pulses only for regsel 0..2 writes.
- `o_parity_err` clears on `i_rst` only.
- `i_msc_commit` copies all three shadows to the active outputs at once. It is honoured in any FSM state.

## Timing
- Reset: every active output, every shadow register, `o_busy`, `o_cfg_written`, `o_frame_err` and `o_parity_err` = 0; FSM = IDLE. This leaves the pad as input, input-disabled, no pull, muxsel 0.
- Reset asserted mid-frame aborts the frame. A frame already in progress when reset releases is seen from its remaining bits and fails the length check.
- Shadow write and the `o_cfg_written`/`o_frame_err` pulse: on the edge ending the CHECK cycle. That is 2 edges after the first cycle with `i_msc_frame`=0.
- Commit: active outputs update on the edge ending the cycle in which `i_msc_commit`=1 (1-cycle latency).
- Commit in the same cycle as a CHECK write: the active outputs take the old shadow; the new value needs a later commit.
- `i_msc_frame` reasserted during CHECK: ignored; the new frame is seen from IDLE on the next cycle.
- Minimum frame gap is 2 cycles.

## Configuration
- `PINMUX_MSC_PARITY_EN` defined: FRAME_LEN = 45 and even parity is checked.
- Undefined: FRAME_LEN = 44, no parity bit, and `o_parity_err` is tied to 0.

## Test plan
- Reset, then sample: all outputs 0; `o_busy`=0.
- Unicast frame to CELL_INDEX, regsel 0, data 16'hF801, commit 3 cycles later → muxsel=5'h1F and amsel=1; `o_cfg_written` pulsed once; outputs unchanged before commit.
- Broadcast frame, regsel 1, data 32'hA5A5_0001 → shadow1 written. A frame to a different address, regsel 1, data 32'hFFFF_FFFF → no pulse. After commit, `in_function_en_out_mscbus`=32'hA5A5_0001.
- 43-bit frame → `o_frame_err` pulse; shadows unchanged. 50-bit frame → `o_frame_err` pulse.
- Parity-flipped frame (with macro) → `o_parity_err`=1, sticky until reset; no write.
- CHECK write to regsel 2 coincident with commit → active outputs take the old shadow2. A second commit → `pes_en_out_mscbus` shows the new value.

Source files
------------

// File: rtl/pinmux_msc_cfg_node.sv
// rtl/pinmux_msc_cfg_node.sv - per-pin MSC serial config receiver with shadow/active registers
// Optional frame parity bit is enabled by defining PINMUX_MSC_PARITY_EN.
module pinmux_msc_cfg_node #(
    parameter int CELL_INDEX = 0,
    parameter int ADDR_WIDTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_msc_frame,
    input  logic        i_msc_valid,
    input  logic        i_msc_sdi,
    input  logic        i_msc_commit,
    output logic        amsel_out_mscbus,
    output logic        ds0_out_mscbus,
    output logic        ds1_out_mscbus,
    output logic        slew_out_mscbus,
    output logic        schmitt_out_mscbus,
    output logic        mode0_out_mscbus,
    output logic        mode1_out_mscbus,
    output logic        inena_out_mscbus,
    output logic        dir_out_mscbus,
    output logic        pull_en_out_mscbus,
    output logic        pull_type_out_mscbus,
    output logic [4:0]  pinmux_muxsel_out_mscbus,
    output logic [31:0] in_function_en_out_mscbus,
    output logic [1:0]  glitch_filter_debounce_clk_sel_out_mscbus,
    output logic [2:0]  glitch_filter_bypass_out_mscbus,
    output logic [7:0]  pes_en_out_mscbus,
    output logic        pes_in_en_out_mscbus,
    output logic [1:0]  pes_safeval_out_mscbus,
    output logic        o_cfg_written,
    output logic        o_frame_err,
    output logic        o_parity_err,
    output logic        o_busy
);

`ifdef PINMUX_MSC_PARITY_EN
    localparam int FRAME_LEN = 45;
`else
    localparam int FRAME_LEN = 44;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t                 state_q;
    logic [FRAME_LEN-1:0]   sr_q;
    logic [FRAME_LEN-1:0]   sr_d;
    logic [5:0]             cnt_q;
    logic [5:0]             cnt_d;
    logic [15:0]            sh0_q;
    logic [31:0]            sh1_q;
    logic [15:0]            sh2_q;
    logic [15:0]            act0_q;
    logic [31:0]            act1_q;
    logic [15:0]            act2_q;
    logic                   parity_err_q;

    logic [ADDR_WIDTH-1:0]  frm_addr;
    logic [3:0]             frm_regsel;
    logic [31:0]            frm_data;
    logic                   len_ok;
    logic                   addr_hit;
    logic                   parity_bad;

    assign sr_d  = {sr_q[FRAME_LEN-2:0], i_msc_sdi};
    assign cnt_d = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;

    // Fields sit at the top of the shift register once exactly FRAME_LEN bits arrived.
    assign frm_addr   = sr_q[FRAME_LEN-1 -: ADDR_WIDTH];
    assign frm_regsel = sr_q[FRAME_LEN-1-ADDR_WIDTH -: 4];
    assign frm_data   = sr_q[FRAME_LEN-5-ADDR_WIDTH -: 32];
    assign len_ok     = (cnt_q == 6'(FRAME_LEN));
    assign addr_hit   = (frm_addr == ADDR_WIDTH'(CELL_INDEX)) ||
                        (frm_addr == {ADDR_WIDTH{1'b1}});

`ifdef PINMUX_MSC_PARITY_EN
    assign parity_bad = ^sr_q;
`else
    assign parity_bad = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            sr_q          <= '0;
            cnt_q         <= '0;
            sh0_q         <= '0;
            sh1_q         <= '0;
            sh2_q         <= '0;
            act0_q        <= '0;
            act1_q        <= '0;
            act2_q        <= '0;
            parity_err_q  <= 1'b0;
            o_cfg_written <= 1'b0;
            o_frame_err   <= 1'b0;
        end else begin
            o_cfg_written <= 1'b0;
            o_frame_err   <= 1'b0;

            // Commit samples the shadows before any same-edge CHECK write lands.
            if (i_msc_commit) begin
                act0_q <= sh0_q;
                act1_q <= sh1_q;
                act2_q <= sh2_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (i_msc_frame) begin
                        state_q <= ST_SHIFT;
                        cnt_q   <= i_msc_valid ? 6'd1 : 6'd0;
                        if (i_msc_valid) begin
                            sr_q <= sr_d;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (!i_msc_frame) begin
                        state_q <= ST_CHECK;
                    end else if (i_msc_valid) begin
                        cnt_q <= cnt_d;
                        sr_q  <= sr_d;
                    end
                end
                ST_CHECK: begin
                    state_q <= ST_IDLE;
                    if (!len_ok) begin
                        o_frame_err <= 1'b1;
                    end else if (parity_bad) begin
                        parity_err_q <= 1'b1;
                    end else if (addr_hit) begin
                        case (frm_regsel)
                            4'd0: begin
                                sh0_q         <= frm_data[15:0];
                                o_cfg_written <= 1'b1;
                            end
                            4'd1: begin
                                sh1_q         <= frm_data;
                                o_cfg_written <= 1'b1;
                            end
                            4'd2: begin
                                sh2_q         <= frm_data[15:0];
                                o_cfg_written <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_busy       = (state_q != ST_IDLE);
    assign o_parity_err = parity_err_q;

    assign {pinmux_muxsel_out_mscbus, pull_type_out_mscbus, pull_en_out_mscbus,
            dir_out_mscbus, inena_out_mscbus, mode1_out_mscbus, mode0_out_mscbus,
            schmitt_out_mscbus, slew_out_mscbus, ds1_out_mscbus, ds0_out_mscbus,
            amsel_out_mscbus} = act0_q;
    assign in_function_en_out_mscbus = act1_q;
    assign {pes_safeval_out_mscbus, pes_in_en_out_mscbus, pes_en_out_mscbus,
            glitch_filter_bypass_out_mscbus,
            glitch_filter_debounce_clk_sel_out_mscbus} = act2_q;

endmodule

// File: tb/tb_pinmux_msc_cfg_node.sv
// tb/tb_pinmux_msc_cfg_node.sv - scoreboard bench for pinmux_msc_cfg_node
module tb_pinmux_msc_cfg_node;

    localparam int CI = 5;
`ifdef PINMUX_MSC_PARITY_EN
    localparam int FL  = 45;
    localparam bit PAR = 1'b1;
`else
    localparam int FL  = 44;
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_msc_frame, i_msc_valid, i_msc_sdi, i_msc_commit;
    logic        amsel, ds0, ds1, slew, schmitt, mode0, mode1, inena, dir, pull_en, pull_type;
    logic [4:0]  muxsel;
    logic [31:0] in_fn;
    logic [1:0]  clk_sel;
    logic [2:0]  bypass;
    logic [7:0]  pes_en;
    logic        pes_in_en;
    logic [1:0]  pes_safeval;
    logic        cfg_written, frame_err, parity_err, busy;

    always #5 clk = ~clk;

    pinmux_msc_cfg_node #(.CELL_INDEX(CI), .ADDR_WIDTH(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_msc_frame(i_msc_frame), .i_msc_valid(i_msc_valid),
        .i_msc_sdi(i_msc_sdi), .i_msc_commit(i_msc_commit),
        .amsel_out_mscbus(amsel), .ds0_out_mscbus(ds0), .ds1_out_mscbus(ds1),
        .slew_out_mscbus(slew), .schmitt_out_mscbus(schmitt),
        .mode0_out_mscbus(mode0), .mode1_out_mscbus(mode1),
        .inena_out_mscbus(inena), .dir_out_mscbus(dir),
        .pull_en_out_mscbus(pull_en), .pull_type_out_mscbus(pull_type),
        .pinmux_muxsel_out_mscbus(muxsel),
        .in_function_en_out_mscbus(in_fn),
        .glitch_filter_debounce_clk_sel_out_mscbus(clk_sel),
        .glitch_filter_bypass_out_mscbus(bypass),
        .pes_en_out_mscbus(pes_en), .pes_in_en_out_mscbus(pes_in_en),
        .pes_safeval_out_mscbus(pes_safeval),
        .o_cfg_written(cfg_written), .o_frame_err(frame_err),
        .o_parity_err(parity_err), .o_busy(busy)
    );

    // Active outputs regrouped into register images: {reg1, reg0[15:0], reg2[15:0]}
    logic [63:0] act_vec;
    assign act_vec = {in_fn,
                      muxsel, pull_type, pull_en, dir, inena, mode1, mode0,
                      schmitt, slew, ds1, ds0, amsel,
                      pes_safeval, pes_in_en, pes_en, bypass, clk_sel};

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: register images and pending expectations
    logic [31:0] m_sh [3];
    logic [63:0] m_act;
    bit          m_par;
    int          ev_q[$];
    logic [63:0] act_q[$];

    function automatic logic [63:0] shadow_vec();
        return {m_sh[1], m_sh[0][15:0], m_sh[2][15:0]};
    endfunction

    // Monitor: pops expectations whenever the DUT shows a pulse or a commit lands
    logic commit_seen = 1'b0;
    always @(posedge clk) commit_seen <= (rst === 1'b0) && (i_msc_commit === 1'b1);

    always @(negedge clk) begin
        if (cfg_written === 1'b1 || frame_err === 1'b1) begin
            int got;
            got = (cfg_written === 1'b1) ? 1 : 2;
            if (ev_q.size() == 0) chk("unexpected_pulse", 64'(got), 64'd0);
            else                  chk("pulse_kind", 64'(got), 64'(ev_q.pop_front()));
        end
        if (commit_seen) begin
            if (act_q.size() == 0) chk("unexpected_commit", 64'd1, 64'd0);
            else                   chk("active_after_commit", act_vec, act_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_commit();
        m_act = shadow_vec();
        act_q.push_back(m_act);
        i_msc_commit = 1'b1;
        tick();
        i_msc_commit = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [7:0] addr, input logic [3:0] rs,
                              input logic [31:0] data, input bit flip, input bit commit_in_check);
        logic [63:0] bits;
        logic [63:0] old;
        bits = {$urandom, $urandom};
        bits[63 -: 44] = {addr, rs, data};
        bits[19] = (^{addr, rs, data}) ^ flip;
        old = shadow_vec();
        if (len != FL) begin
            ev_q.push_back(2);
        end else if (PAR && flip) begin
            m_par = 1'b1;
        end else if ((addr == 8'(CI) || addr == 8'hFF) && rs < 4'd3) begin
            ev_q.push_back(1);
            m_sh[rs] = (rs == 4'd1) ? data : {16'h0, data[15:0]};
        end
        i_msc_frame = 1'b1;
        for (int i = 0; i < len; ) begin
            if ($urandom_range(0, 3) == 0) begin
                i_msc_valid = 1'b0;
                i_msc_sdi   = 1'($urandom);
            end else begin
                i_msc_valid = 1'b1;
                i_msc_sdi   = bits[63 - i];
                i++;
            end
            tick();
        end
        chk("busy_in_frame", 64'(busy), 64'd1);
        i_msc_frame = 1'b0;
        i_msc_valid = 1'b0;
        tick();
        if (commit_in_check) begin
            m_act = old;
            act_q.push_back(old);
            i_msc_commit = 1'b1;
        end
        tick();
        i_msc_commit = 1'b0;
        tick();
        chk("parity_err", 64'(parity_err), 64'(m_par));
        chk("active_hold", act_vec, m_act);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout vectors=%0d", vec_cnt);
        $fatal(1);
    end

    initial begin
        logic [7:0] a;
        int         ln;
        for (int k = 0; k < 3; k++) m_sh[k] = '0;
        m_act = '0;
        m_par = 1'b0;
        rst = 1'b1;
        i_msc_frame = 1'b0; i_msc_valid = 1'b0; i_msc_sdi = 1'b0; i_msc_commit = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_active", act_vec, 64'd0);
        chk("reset_flags", {60'd0, busy, cfg_written, frame_err, parity_err}, 64'd0);

        send_frame(FL, 8'(CI), 4'd0, 32'h0000_F801, 1'b0, 1'b0);
        tick(); tick();
        do_commit();
        chk("muxsel", 64'(muxsel), 64'h1F);
        chk("amsel", 64'(amsel), 64'd1);

        send_frame(FL, 8'hFF, 4'd1, 32'hA5A5_0001, 1'b0, 1'b0);
        send_frame(FL, 8'(CI + 1), 4'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_commit();
        chk("in_function_en", 64'(in_fn), 64'hA5A5_0001);

        send_frame(43, 8'(CI), 4'd0, 32'h0000_0000, 1'b0, 1'b0);
        send_frame(50, 8'(CI), 4'd0, 32'h0000_0000, 1'b0, 1'b0);
        do_commit();

        send_frame(FL, 8'(CI), 4'd2, 32'h0000_0055, 1'b1, 1'b0);
        send_frame(FL, 8'(CI), 4'd0, 32'h0000_0003, 1'b0, 1'b0);
        do_commit();

        send_frame(FL, 8'(CI), 4'd2, 32'h0000_1234, 1'b0, 1'b1);
        do_commit();
        chk("pes_en", 64'(pes_en), 64'h91);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0:       a = 8'(CI);
                1:       a = 8'hFF;
                default: a = 8'($urandom);
            endcase
            ln = ($urandom_range(0, 5) == 0) ? int'($urandom_range(40, 50)) : FL;
            send_frame(ln, a, 4'($urandom_range(0, 5)), $urandom,
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) do_commit();
        end

        repeat (4) tick();
        chk("events_drained", 64'(ev_q.size()), 64'd0);
        chk("commits_drained", 64'(act_q.size()), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("parity_err_after_reset", 64'(parity_err), 64'd0);
        chk("active_after_reset", act_vec, 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
